// File: rtl/pulse_bram_reader_pkg.sv
// Shared definitions for the pulse BRAM reader: FSM encoding, default geometry and the fp32 zero
// word written back when read-clear is enabled.
package pulse_bram_reader_pkg;

    localparam int unsigned DEFAULT_DEPTH     = 1024;
    localparam int unsigned DEFAULT_ADDR_STEP = 4;
    localparam logic [31:0] FP32_ZERO         = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StOut,
        StClr,
        StDone
    } state_e;

    // Readout length is bounded by the BRAM size so addresses can never run past the last word.
    function automatic logic [31:0] clamp_count(input logic [31:0] n, input int unsigned depth);
        return (n > depth) ? depth : n;
    endfunction

endpackage

// File: rtl/pulse_bram_reader_if.sv
// Request, BRAM port and sample stream signals of the pulse BRAM reader.
// master: the reader; slave: the surrounding BRAM and stream consumer.
interface pulse_bram_reader_if;

    logic        start;
    logic [31:0] num_words;
    logic [31:0] bram_addr_pulse;
    logic [31:0] bram_data_in_pulse;
    logic        bram_we_pulse;
    logic        ena_pulse;
    logic [31:0] bram_data_out_pulse;
    logic [31:0] sample_data;
    logic [31:0] sample_index;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        done;

    modport master (
        input  start, num_words, bram_data_out_pulse, sample_ready,
        output bram_addr_pulse, bram_data_in_pulse, bram_we_pulse, ena_pulse,
        output sample_data, sample_index, sample_valid, busy, done
    );

    modport slave (
        output start, num_words, bram_data_out_pulse, sample_ready,
        input  bram_addr_pulse, bram_data_in_pulse, bram_we_pulse, ena_pulse,
        input  sample_data, sample_index, sample_valid, busy, done
    );

endinterface

// File: rtl/pulse_bram_reader.sv
// Streams fp32 samples out of the pulse BRAM one word at a time with a valid/ready handshake.
// Define PULSE_READ_CLEAR_EN to zero each word in the BRAM after it has been handed off.
module pulse_bram_reader
    import pulse_bram_reader_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned ADDR_STEP = DEFAULT_ADDR_STEP
) (
    input logic                 clk,
    input logic                 rst,
    pulse_bram_reader_if.master bus
);

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] index_q, index_d;
    logic        wait_q, wait_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] sample_data_q, sample_data_d;
    logic [31:0] sample_index_q, sample_index_d;
    logic        valid_q, valid_d;
    logic        ena_q, ena_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef PULSE_READ_CLEAR_EN
    logic        we_q, we_d;
`endif

    logic handshake;
    logic last_word;

    assign handshake = (state_q == StOut) && valid_q && bus.sample_ready;
    assign last_word = (index_q + 32'd1) == count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        wait_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    count_d = clamp_count(bus.num_words, DEPTH);
                    index_d = '0;
                    state_d = (count_d == '0) ? StDone : StRdReq;
                end
            end
            StRdReq: state_d = StRdWait;
            // Two cycles here: one for the BRAM read latency, one to capture the read data.
            StRdWait: begin
                wait_d = ~wait_q;
                if (wait_q) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (handshake) begin
`ifdef PULSE_READ_CLEAR_EN
                    state_d = StClr;
`else
                    index_d = index_q + 32'd1;
                    state_d = last_word ? StDone : StRdReq;
`endif
                end
            end
            StClr: begin
`ifdef PULSE_READ_CLEAR_EN
                index_d = index_q + 32'd1;
                state_d = last_word ? StDone : StRdReq;
`else
                state_d = StIdle;
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are derived from the state being entered so they change on the same edge as it.
    always_comb begin
        addr_d         = addr_q;
        sample_data_d  = sample_data_q;
        sample_index_d = sample_index_q;
        valid_d        = valid_q;
        ena_d          = (state_d == StRdReq) || (state_d == StClr);
        busy_d         = (state_d != StIdle) && (state_d != StDone);
        done_d         = (state_d == StDone);
`ifdef PULSE_READ_CLEAR_EN
        we_d           = (state_d == StClr);
`endif
        if (state_d == StRdReq) begin
            addr_d = index_d * ADDR_STEP;
        end
        if ((state_q == StRdWait) && wait_q) begin
            sample_data_d  = bus.bram_data_out_pulse;
            sample_index_d = index_q;
            valid_d        = 1'b1;
        end
        if (handshake) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q        <= '0;
            index_q        <= '0;
            wait_q         <= 1'b0;
            addr_q         <= '0;
            sample_data_q  <= '0;
            sample_index_q <= '0;
            valid_q        <= 1'b0;
            ena_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef PULSE_READ_CLEAR_EN
            we_q           <= 1'b0;
`endif
        end else begin
            count_q        <= count_d;
            index_q        <= index_d;
            wait_q         <= wait_d;
            addr_q         <= addr_d;
            sample_data_q  <= sample_data_d;
            sample_index_q <= sample_index_d;
            valid_q        <= valid_d;
            ena_q          <= ena_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef PULSE_READ_CLEAR_EN
            we_q           <= we_d;
`endif
        end
    end

    // Gating with rst keeps an access already on the port from completing at the reset edge.
    assign bus.ena_pulse          = ena_q & ~rst;
`ifdef PULSE_READ_CLEAR_EN
    assign bus.bram_we_pulse      = we_q & ~rst;
`else
    assign bus.bram_we_pulse      = 1'b0;
`endif
    assign bus.bram_addr_pulse    = addr_q;
    assign bus.bram_data_in_pulse = FP32_ZERO;
    assign bus.sample_data        = sample_data_q;
    assign bus.sample_index       = sample_index_q;
    assign bus.sample_valid       = valid_q;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;

endmodule
